// File: rtl/axi4_ddr_mem_slave.sv
// AXI4 INCR-burst slave memory model with independent read and write FSMs.
// Optional macro AXI_MEM_RLAT_EN adds an R_WAIT state of RD_LATENCY cycles before the first read beat.
`ifndef DDR_DEPTH
`define DDR_DEPTH 256
`endif

module axi4_ddr_mem_slave #(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int DDR_DEPTH          = `DDR_DEPTH,
  parameter int RD_LATENCY         = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          m_axi_awvalid,
  output logic                          m_axi_awready,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_awaddr,
  input  logic [7:0]                    m_axi_awlen,
  input  logic                          m_axi_wvalid,
  output logic                          m_axi_wready,
  input  logic [31:0]                   m_axi_wdata,
  input  logic [3:0]                    m_axi_wstrb,
  input  logic                          m_axi_wlast,
  output logic                          m_axi_bvalid,
  input  logic                          m_axi_bready,
  input  logic                          m_axi_arvalid,
  output logic                          m_axi_arready,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_araddr,
  input  logic [7:0]                    m_axi_arlen,
  output logic                          m_axi_rvalid,
  input  logic                          m_axi_rready,
  output logic [31:0]                   m_axi_rdata,
  output logic                          m_axi_rlast,
  output logic [31:0]                   ddr_mem [0:DDR_DEPTH-1],
  output logic                          wlast_err
);
  localparam int AW = $clog2(DDR_DEPTH);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
`ifdef AXI_MEM_RLAT_EN
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;
`else
  typedef enum logic [1:0] {R_IDLE, R_DATA} r_state_t;
`endif

  w_state_t w_state, w_next;
  r_state_t r_state, r_next;
  logic alive;
  logic [AW-1:0] w_idx, r_idx, r_idx_nxt, aw_idx, ar_idx;
  logic [7:0] w_len, w_cnt, r_len, r_cnt;
  logic aw_hs, w_hs, ar_hs, r_hs, w_final;
  logic unused_addr_bits;
`ifdef AXI_MEM_RLAT_EN
  logic [7:0] wait_cnt;
  logic wait_done;
  assign wait_done = (wait_cnt == 8'(RD_LATENCY - 1));
`endif

  assign unused_addr_bits = ^{m_axi_awaddr[C_M_AXI_ADDR_WIDTH-1:AW+2], m_axi_awaddr[1:0],
                              m_axi_araddr[C_M_AXI_ADDR_WIDTH-1:AW+2], m_axi_araddr[1:0]};
  assign aw_idx    = m_axi_awaddr[2 +: AW];
  assign ar_idx    = m_axi_araddr[2 +: AW];
  assign r_idx_nxt = r_idx + AW'(1);

  // Ready flags stay low through reset and rise one edge after release
  assign m_axi_awready = alive && (w_state == W_IDLE);
  assign m_axi_wready  = (w_state == W_DATA);
  assign m_axi_bvalid  = (w_state == W_RESP);
  assign m_axi_arready = alive && (r_state == R_IDLE);
  assign m_axi_rvalid  = (r_state == R_DATA);
  assign m_axi_rlast   = m_axi_rvalid && (r_cnt == r_len);

  assign aw_hs   = m_axi_awvalid && m_axi_awready;
  assign w_hs    = m_axi_wvalid && m_axi_wready;
  assign ar_hs   = m_axi_arvalid && m_axi_arready;
  assign r_hs    = m_axi_rvalid && m_axi_rready;
  assign w_final = (w_cnt == w_len);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alive   <= 1'b0;
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      alive   <= 1'b1;
      w_state <= w_next;
      r_state <= r_next;
    end
  end

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (aw_hs) w_next = W_DATA;
      W_DATA:  if (w_hs && w_final) w_next = W_RESP;
      W_RESP:  if (m_axi_bready) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
`ifdef AXI_MEM_RLAT_EN
      R_IDLE:  if (ar_hs) r_next = R_WAIT;
      R_WAIT:  if (wait_done) r_next = R_DATA;
`else
      R_IDLE:  if (ar_hs) r_next = R_DATA;
`endif
      R_DATA:  if (r_hs && m_axi_rlast) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  // Beat count decides the end of a write burst; wlast is only cross-checked
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_idx     <= '0;
      w_len     <= '0;
      w_cnt     <= '0;
      wlast_err <= 1'b0;
    end else begin
      if (aw_hs) begin
        w_idx <= aw_idx;
        w_len <= m_axi_awlen;
        w_cnt <= '0;
      end
      if (w_hs) begin
        w_idx <= w_idx + AW'(1);
        w_cnt <= w_cnt + 8'd1;
        if (m_axi_wlast != w_final) wlast_err <= 1'b1;
      end
    end
  end

  // Array contents survive reset
  always_ff @(posedge clk) begin
    if (w_hs) begin
      for (int b = 0; b < 4; b++) begin
        if (m_axi_wstrb[b]) ddr_mem[w_idx][8*b +: 8] <= m_axi_wdata[8*b +: 8];
      end
    end
  end

  // rdata is loaded one beat ahead, so a same-edge write is seen as old data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx       <= '0;
      r_len       <= '0;
      r_cnt       <= '0;
      m_axi_rdata <= '0;
`ifdef AXI_MEM_RLAT_EN
      wait_cnt    <= '0;
`endif
    end else begin
      if (ar_hs) begin
        r_idx <= ar_idx;
        r_len <= m_axi_arlen;
        r_cnt <= '0;
`ifdef AXI_MEM_RLAT_EN
        wait_cnt <= '0;
`else
        m_axi_rdata <= ddr_mem[ar_idx];
`endif
      end
`ifdef AXI_MEM_RLAT_EN
      if (r_state == R_WAIT) begin
        wait_cnt <= wait_cnt + 8'd1;
        if (wait_done) m_axi_rdata <= ddr_mem[r_idx];
      end
`endif
      if (r_hs && !m_axi_rlast) begin
        r_idx       <= r_idx_nxt;
        r_cnt       <= r_cnt + 8'd1;
        m_axi_rdata <= ddr_mem[r_idx_nxt];
      end
    end
  end
endmodule

// File: tb/tb_axi4_ddr_mem_slave.sv
// Directed testbench for axi4_ddr_mem_slave (default build, DDR_DEPTH = 256, no read latency).
module tb_axi4_ddr_mem_slave;
  logic clk = 1'b0;
  logic rst;
  logic awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic arvalid, arready, rvalid, rready, rlast, wlast_err;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [7:0] awlen, arlen;
  logic [3:0] wstrb;
  logic [31:0] ddr_mem [0:255];
  logic [31:0] exp_mem [0:255];
  int vectors = 0;
  int miscompares = 0;

  axi4_ddr_mem_slave dut (
    .clk(clk), .rst(rst),
    .m_axi_awvalid(awvalid), .m_axi_awready(awready), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen),
    .m_axi_wvalid(wvalid), .m_axi_wready(wready), .m_axi_wdata(wdata), .m_axi_wstrb(wstrb),
    .m_axi_wlast(wlast), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_arvalid(arvalid), .m_axi_arready(arready), .m_axi_araddr(araddr), .m_axi_arlen(arlen),
    .m_axi_rvalid(rvalid), .m_axi_rready(rready), .m_axi_rdata(rdata), .m_axi_rlast(rlast),
    .ddr_mem(ddr_mem), .wlast_err(wlast_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Drives one write burst; data is base+i, wlast is raised on beat wlast_beat
  task automatic write_burst(input logic [31:0] addr, input logic [7:0] len, input logic [31:0] base,
                             input logic [3:0] strb, input int wlast_beat);
    logic [7:0] idx;
    awvalid = 1'b1; awaddr = addr; awlen = len; bready = 1'b1;
    @(negedge clk);
    checkOutput("awready", {31'd0, awready}, 32'd1);
    @(posedge clk); #1;
    awvalid = 1'b0;
    idx = addr[9:2];
    for (int i = 0; i <= int'(len); i++) begin
      wvalid = 1'b1; wdata = base + 32'(i); wstrb = strb; wlast = (i == wlast_beat);
      for (int b = 0; b < 4; b++)
        if (strb[b]) exp_mem[idx][8*b +: 8] = wdata[8*b +: 8];
      @(negedge clk);
      checkOutput("wready", {31'd0, wready}, 32'd1);
      checkOutput("bvalid_early", {31'd0, bvalid}, 32'd0);
      @(posedge clk); #1;
      idx = idx + 8'd1;
    end
    wvalid = 1'b0; wlast = 1'b0;
    @(negedge clk);
    checkOutput("bvalid", {31'd0, bvalid}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("bvalid_done", {31'd0, bvalid}, 32'd0);
    @(posedge clk); #1;
  endtask

  // Reads a burst and compares each beat against the bench's memory model
  task automatic read_burst(input logic [31:0] addr, input logic [7:0] len, input bit toggle);
    logic [7:0] idx;
    arvalid = 1'b1; araddr = addr; arlen = len;
    @(negedge clk);
    checkOutput("arready", {31'd0, arready}, 32'd1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    idx = addr[9:2];
    for (int i = 0; i <= int'(len); i++) begin
      if (toggle) begin
        rready = 1'b0;
        @(negedge clk);
        checkOutput("rvalid_stall", {31'd0, rvalid}, 32'd1);
        checkOutput("rdata_stall", rdata, exp_mem[idx]);
        checkOutput("rlast_stall", {31'd0, rlast}, {31'd0, i == int'(len)});
        @(posedge clk); #1;
      end
      rready = 1'b1;
      @(negedge clk);
      checkOutput("rvalid", {31'd0, rvalid}, 32'd1);
      checkOutput("rdata", rdata, exp_mem[idx]);
      checkOutput("rlast", {31'd0, rlast}, {31'd0, i == int'(len)});
      @(posedge clk); #1;
      idx = idx + 8'd1;
    end
    rready = 1'b0;
    @(negedge clk);
    checkOutput("rvalid_done", {31'd0, rvalid}, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    awvalid = 0; awaddr = 0; awlen = 0; wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 0;
    arvalid = 0; araddr = 0; arlen = 0; rready = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_awready", {31'd0, awready}, 32'd0);
    checkOutput("rst_arready", {31'd0, arready}, 32'd0);
    checkOutput("rst_wready", {31'd0, wready}, 32'd0);
    checkOutput("rst_bvalid", {31'd0, bvalid}, 32'd0);
    checkOutput("rst_rvalid", {31'd0, rvalid}, 32'd0);
    checkOutput("rst_rlast", {31'd0, rlast}, 32'd0);
    checkOutput("rst_rdata", rdata, 32'd0);
    checkOutput("rst_wlast_err", {31'd0, wlast_err}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic 4-beat write and read-back
    write_burst(32'h100, 8'd3, 32'hA0, 4'hF, 3);
    checkOutput("mem64", ddr_mem[64], 32'hA0);
    checkOutput("mem67", ddr_mem[67], 32'hA3);
    checkOutput("wlast_err_clean", {31'd0, wlast_err}, 32'd0);
    read_burst(32'h100, 8'd3, 1'b0);

    // Byte strobes merge over prior contents
    write_burst(32'h0, 8'd0, 32'hFFFFFFFF, 4'hF, 0);
    write_burst(32'h0, 8'd0, 32'h11223344, 4'h5, 0);
    checkOutput("strb_merge", ddr_mem[0], 32'hFF22FF44);

    // Wrapping write and stalled wrapping read across the top of the array
    write_burst(32'h3F0, 8'd7, 32'hC0, 4'hF, 7);
    checkOutput("wrap_mem255", ddr_mem[255], 32'hC3);
    checkOutput("wrap_mem0", ddr_mem[0], 32'hC4);
    read_burst(32'h3F0, 8'd7, 1'b1);

    // Concurrent 16-beat write and 16-beat read on disjoint regions
    write_burst(32'h110, 8'd11, 32'hB0, 4'hF, 11);
    fork
      write_burst(32'h200, 8'd15, 32'hD00, 4'hF, 15);
      read_burst(32'h100, 8'd15, 1'b0);
    join
    checkOutput("conc_mem128", ddr_mem[128], 32'hD00);
    checkOutput("conc_mem143", ddr_mem[143], 32'hD0F);

    // Early wlast: beat count still governs, error flag is sticky
    write_burst(32'h300, 8'd3, 32'hE0, 4'hF, 1);
    checkOutput("early_mem195", ddr_mem[195], 32'hE3);
    checkOutput("wlast_err_set", {31'd0, wlast_err}, 32'd1);
    write_burst(32'h310, 8'd0, 32'hE8, 4'hF, 0);
    checkOutput("wlast_err_sticky", {31'd0, wlast_err}, 32'd1);

    // Reset in the middle of an 8-beat read
    arvalid = 1'b1; araddr = 32'h100; arlen = 8'd7;
    @(posedge clk); #1;
    arvalid = 1'b0; rready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("abort_rvalid", {31'd0, rvalid}, 32'd0);
    checkOutput("abort_rdata", rdata, 32'd0);
    checkOutput("abort_wlast_err", {31'd0, wlast_err}, 32'd0);
    rready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("post_rst_arready", {31'd0, arready}, 32'd1);
    checkOutput("post_rst_awready", {31'd0, awready}, 32'd1);
    checkOutput("persist_mem64", ddr_mem[64], 32'hA0);
    @(posedge clk); #1;
    read_burst(32'h300, 8'd3, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=completion");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule

// File: doc/axi4_ddr_mem_slave.md
# axi4_ddr_mem_slave

AXI4 slave memory model that terminates the vector core's `axi4_if` master port. It services incrementing write bursts (AW/W/B) and read bursts (AR/R) against a word-addressed DDR array, and exposes that array as `ddr_mem` for scoreboard inspection. The read and write channels run as independent state machines, so one read burst and one write burst can be in flight at the same time.

## Interface
- `C_M_AXI_ADDR_WIDTH`, 32, byte address width.
- `C_M_AXI_DATA_WIDTH`, 32, data width; fixed at 32 (one word per beat).
- `DDR_DEPTH`, `` `DDR_DEPTH ``, number of 32-bit words; must be a power of two.
- `RD_LATENCY`, 4, extra AR-to-first-R cycles; used only with `AXI_MEM_RLAT_EN`.
- `clk` input 1: the single clock; all state changes on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `m_axi_awvalid`/`m_axi_awready` input/output 1: write address handshake.
- `m_axi_awaddr` input 32: write burst start byte address.
- `m_axi_awlen` input 8: write burst beats minus 1.
- `m_axi_wvalid`/`m_axi_wready` input/output 1: write data handshake.
- `m_axi_wdata` input 32: write beat data.
- `m_axi_wstrb` input 4: byte enables.
- `m_axi_wlast` input 1: last write beat.
- `m_axi_bvalid` output 1 / `m_axi_bready` input 1: write response handshake (no resp code).
- `m_axi_arvalid`/`m_axi_arready` input/output 1: read address handshake.
- `m_axi_araddr` input 32: read burst start byte address.
- `m_axi_arlen` input 8: read burst beats minus 1.
- `m_axi_rvalid` output 1 / `m_axi_rready` input 1: read data handshake.
- `m_axi_rdata` output 32: read beat data.
- `m_axi_rlast` output 1: last read beat.
- `ddr_mem` output `DDR_DEPTH` x 32: live array contents.
- `wlast_err` output 1: sticky error flag; set when `wlast` disagrees with the beat count.

## Operation
- Word index = `addr[2 +: log2(DDR_DEPTH)]`. Bits [1:0] are ignored. Higher bits are dropped, so addressing wraps modulo `DDR_DEPTH`.
- Only INCR bursts are supported. The index increments by 1 per beat and wraps from `DDR_DEPTH-1` to 0 mid-burst.
- Write FSM has three states:
  - W_IDLE: `awready`=1. On AW handshake, latch index and `awlen`, clear beat counter, go to W_DATA.
  - W_DATA: `wready`=1. On each W handshake, write every byte whose `wstrb` bit is set, increment index and counter. On beat `awlen`, go to W_RESP.
  - W_RESP: `bvalid`=1. On `bready`, go to W_IDLE.
- Write beat count is authoritative. `wlast` high before beat `awlen`, or low on beat `awlen`, sets `wlast_err`. The FSM ignores `wlast` for sequencing.
- Read FSM:
  - R_IDLE: `arready`=1. On AR handshake, latch index and `arlen`, go to R_DATA (or R_WAIT if latency is enabled).
  - R_DATA: `rvalid`=1. `rdata` is registered from the array; `rlast` is high when counter == `arlen`. On each R handshake, advance to the next word. After the last beat, go to R_IDLE.
- `rdata`/`rvalid`/`rlast` hold stable while `rready` is low.
- Same-cycle write and read-load at the same index: the read gets the pre-write (old) data.
- Array contents are not reset; they persist across `rst`.
- `wlast_err` is cleared only by `rst`.

## Timing
- Reset values: `awready`=0, `wready`=0, `bvalid`=0, `arready`=0, `rvalid`=0, `rlast`=0, `rdata`=0, `wlast_err`=0. Both FSMs are in IDLE.
- `awready` and `arready` assert the first cycle after `rst` deasserts.
- `awready` is registered: no AW accept while in W_DATA or W_RESP. Same rule for AR outside R_IDLE.
- Write latency: AW handshake in cycle N, so `wready` high in N+1. Last W handshake in M, so `bvalid` high in M+1. Throughput is one beat per cycle.
- Read latency: AR handshake in cycle N, so `rvalid` with beat 0 in N+1. With `rready` held high, one beat per cycle and the last beat at N+1+`arlen`.
- Mid-burst `rst` aborts both FSMs immediately. Words already written stay written; no B or R is issued for the aborted bursts.

## Configuration
- `AXI_MEM_RLAT_EN` defined: adds state R_WAIT between R_IDLE and R_DATA. R_WAIT holds `RD_LATENCY` cycles, so first `rvalid` is at N+1+`RD_LATENCY`. Beat-to-beat timing is unchanged.
- `AXI_MEM_RLAT_EN` undefined: no R_WAIT state, `RD_LATENCY` is ignored, and first `rvalid` is at N+1.

## Test plan
- Write 4 beats at 0x100, `awlen`=3, data 0xA0..0xA3, `wstrb`=0xF, `bready`=1 → `ddr_mem[64..67]`=0xA0..0xA3; `bvalid` one cycle after the last beat; `wlast_err`=0.
- Write 0x11223344 at 0x0 with `wstrb`=0x5, over prior 0xFFFFFFFF → `ddr_mem[0]`=0xFF22FF44.
- Read `arlen`=7 from index `DDR_DEPTH-4` with `rready` toggling 1/0 → 8 beats in order, wrapping to index 0; `rlast` only on beat 7; data stable during stalls.
- Concurrent 16-beat write and 16-beat read to disjoint regions → both complete with no inserted bubbles, and B arrives independently of R.
- Write `awlen`=3 with `wlast` on beat 1 → 4 words written, `bvalid` after beat 3, `wlast_err`=1 until `rst`.
- Assert `rst` in the middle of an 8-beat read → `rvalid`=0 immediately; `arready`=1 the cycle after release; a new read returns correct data.
